// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among N_MASTERS
// masters. The grant is held for the owner's whole CYC, so multi-beat cycles
// stay atomic. Every change of owner passes through at least one IDLE cycle.
// Optional macro WB_ARB_TIMEOUT_EN adds a stalled-slave watchdog. The
// watchdog drives an o_M_ERR pulse and forcibly releases the grant.
module wishbone_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                               i_CLK,
  input  logic                               i_RST,
  input  logic [N_MASTERS-1:0]               i_M_CYC,
  input  logic [N_MASTERS-1:0]               i_M_STB,
  input  logic [N_MASTERS-1:0]               i_M_WE,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]    i_M_ADDR,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]    i_M_DATA,
  input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] i_M_SEL,
  output logic [DATA_WIDTH-1:0]              o_M_DATA,
  output logic [N_MASTERS-1:0]               o_M_ACK,
  output logic [N_MASTERS-1:0]               o_M_GNT,
  output logic                               o_S_CYC,
  output logic                               o_S_STB,
  output logic                               o_S_WE,
  output logic [ADDR_WIDTH-1:0]              o_S_ADDR,
  output logic [DATA_WIDTH-1:0]              o_S_DATA,
  output logic [DATA_WIDTH/8-1:0]            o_S_SEL,
  input  logic [DATA_WIDTH-1:0]              i_S_DATA,
  input  logic                               i_S_ACK
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic [N_MASTERS-1:0]               o_M_ERR
`endif
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N_MASTERS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [N_MASTERS-1:0] gnt_nxt;
  logic [IDX_W-1:0]    last_grant, last_nxt;   // doubles as owner index in GRANT
  logic [IDX_W-1:0]    sel_idx, cand;
  logic                found;
  logic                timeout;

  // Per-master views of the packed buses
  logic [ADDR_WIDTH-1:0] m_addr [N_MASTERS];
  logic [DATA_WIDTH-1:0] m_data [N_MASTERS];
  logic [SEL_W-1:0]      m_sel  [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
    assign m_addr[k] = i_M_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_data[k] = i_M_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    assign m_sel[k]  = i_M_SEL[k*SEL_W +: SEL_W];
  end

  logic own_cyc, own_stb;
  assign own_cyc = i_M_CYC[last_grant];
  assign own_stb = i_M_STB[last_grant];

  // Round-robin search: first requester above last_grant, wrapping around
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    found   = 1'b0;
    sel_idx = last_grant;
    cand    = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % N_MASTERS);
      if (!found && i_M_CYC[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on owner CYC drop or timeout
  always_comb begin
    state_nxt = state;
    gnt_nxt   = o_M_GNT;
    last_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N_MASTERS-1){1'b0}}, 1'b1} << sel_idx;
          last_nxt  = sel_idx;
        end
      end
      GRANT: begin
        if (timeout || !own_cyc) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= IDLE;
      o_M_GNT    <= '0;
      last_grant <= IDX_W'(N_MASTERS - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= state_nxt;
      o_M_GNT    <= gnt_nxt;
      last_grant <= last_nxt;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == GRANT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign o_M_ERR = timeout ? o_M_GNT : '0;

  // Watchdog: counts owner strobe cycles without ACK, cleared on ACK or state change
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wait_cnt <= '0;
    end else if (state != GRANT || state_nxt != GRANT || i_S_ACK) begin
      wait_cnt <= '0;
    end else if (own_cyc && own_stb) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Slave-side mux of the owner's signals; ACK routed to the owner only
  always_comb begin
    o_S_CYC  = 1'b0;
    o_S_STB  = 1'b0;
    o_S_WE   = 1'b0;
    o_S_ADDR = '0;
    o_S_DATA = '0;
    o_S_SEL  = '0;
    o_M_ACK  = '0;
    if (state == GRANT) begin
      o_S_CYC  = own_cyc;
      o_S_STB  = own_stb;
      o_S_WE   = i_M_WE[last_grant];
      o_S_ADDR = m_addr[last_grant];
      o_S_DATA = m_data[last_grant];
      o_S_SEL  = m_sel[last_grant];
      o_M_ACK  = o_M_GNT & {N_MASTERS{i_S_ACK}};
      if (timeout) begin
        o_S_CYC = 1'b0;
        o_S_STB = 1'b0;
        o_M_ACK = '0;
      end
    end
  end

  assign o_M_DATA = i_S_DATA;

endmodule
